// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and one downstream consumer.
// master: the arbiter side. slave: the requester/consumer side.
interface mux2_rr_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req0;
    logic [WIDTH-1:0] in0;
    logic             last0;
    logic             gnt0;
    logic             req1;
    logic [WIDTH-1:0] in1;
    logic             last1;
    logic             gnt1;
    logic             out_valid;
    logic [WIDTH-1:0] out;
    logic             out_ready;
    logic             sel;
    logic             busy;

    modport master (
        input  req0, in0, last0, req1, in1, last1, out_ready,
        output gnt0, gnt1, out_valid, out, sel, busy
    );

    modport slave (
        output req0, in0, last0, req1, in1, last1, out_ready,
        input  gnt0, gnt1, out_valid, out, sel, busy
    );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Round-robin packet arbiter driving a shared 2:1 mux channel.
// Grants whole packets, capped at MAX_BURST beats per grant, and alternates
// fairly when both requesters are active.
// Optional macro MUX2_RR_ARBITER_STATS_EN adds saturating transfer counters
// cnt0/cnt1.
module mux2_rr_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux2_rr_arbiter_if.master    bus
`ifdef MUX2_RR_ARBITER_STATS_EN
    ,
    output logic [15:0]          cnt0,
    output logic [15:0]          cnt1
`endif
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             last_served_q, last_served_d;

    logic             act_id;
    logic             act_req;
    logic             act_last;
    logic             oth_req;
    logic             xfer;
    logic             rel;
    logic [CNT_W-1:0] cnt_inc;

    // State, beat counter and fairness pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            beat_cnt_q    <= '0;
            last_served_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            last_served_q <= last_served_d;
        end
    end

    // Output decode straight from the registered state.
    always_comb begin
        bus.sel       = (state_q == GRANT1);
        bus.busy      = (state_q != IDLE);
        bus.out_valid = ((state_q == GRANT0) && bus.req0) || ((state_q == GRANT1) && bus.req1);
        bus.gnt0      = (state_q == GRANT0) && bus.out_ready;
        bus.gnt1      = (state_q == GRANT1) && bus.out_ready;
        case (state_q)
            GRANT0:  bus.out = bus.in0;
            GRANT1:  bus.out = bus.in1;
            default: bus.out = WIDTH'(0);
        endcase
    end

    // Next-state: arbitration in IDLE, release/re-arbitration in a grant.
    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        last_served_d = last_served_q;
        act_id        = (state_q == GRANT1);
        act_req       = act_id ? bus.req1  : bus.req0;
        act_last      = act_id ? bus.last1 : bus.last0;
        oth_req       = act_id ? bus.req0  : bus.req1;
        xfer          = 1'b0;
        rel           = 1'b0;
        cnt_inc       = beat_cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                beat_cnt_d = '0;
                if (bus.req0 && bus.req1) begin
                    state_d = last_served_q ? GRANT0 : GRANT1;
                end else if (bus.req0) begin
                    state_d = GRANT0;
                end else if (bus.req1) begin
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                xfer = act_req && bus.out_ready;
                rel  = !act_req || (xfer && (act_last || (cnt_inc == BURST_LIM)));
                if (xfer) begin
                    beat_cnt_d = cnt_inc;
                end
                if (rel) begin
                    // Other side first; same side only if nobody else waits.
                    beat_cnt_d    = '0;
                    last_served_d = act_id;
                    if (oth_req) begin
                        state_d = act_id ? GRANT0 : GRANT1;
                    end else if (act_req) begin
                        state_d = state_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

`ifdef MUX2_RR_ARBITER_STATS_EN
    // Saturating per-requester accepted-transfer counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if ((state_q == GRANT0) && bus.req0 && bus.out_ready && (cnt0 != 16'hFFFF)) begin
                cnt0 <= cnt0 + 16'd1;
            end
            if ((state_q == GRANT1) && bus.req1 && bus.out_ready && (cnt1 != 16'hFFFF)) begin
                cnt1 <= cnt1 + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter (WIDTH=8, MAX_BURST=4).
// Requester 0 beats carry 8'h10+k, requester 1 beats carry 8'h80+k.
module tb_mux2_rr_arbiter;
    logic clk;
    logic rst_n;

    mux2_rr_arbiter_if #(.WIDTH(8)) bus ();

`ifdef MUX2_RR_ARBITER_STATS_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
`endif

    mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
`ifdef MUX2_RR_ARBITER_STATS_EN
        ,
        .cnt0  (cnt0),
        .cnt1  (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {sel, busy, out_valid, gnt0, gnt1, out}
    logic [12:0] obs;
    assign obs = {bus.sel, bus.busy, bus.out_valid, bus.gnt0, bus.gnt1, bus.out};

    int checks = 0;
    int passes = 0;
    int k0 = 0;
    int k1 = 0;
    int len0 = 1;
    int len1 = 1;
    logic [12:0] exp;
    logic [8:0]  ent;

    // Present the current beat of each requester's stream.
    task automatic drive();
        bus.in0   = 8'h10 + 8'(k0);
        bus.last0 = (((k0 + 1) % len0) == 0);
        bus.in1   = 8'h80 + 8'(k1);
        bus.last1 = (((k1 + 1) % len1) == 0);
    endtask

    // One clock: advance each stream by the beat that transferred.
    task automatic advance();
        logic x0, x1;
        x0 = bus.req0 && bus.gnt0;
        x1 = bus.req1 && bus.gnt1;
        @(posedge clk);
        #1;
        if (x0) k0++;
        if (x1) k1++;
        drive();
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req0      = 1'b0;
        bus.req1      = 1'b0;
        bus.out_ready = 1'b1;
        k0 = 0;
        k1 = 0;
        drive();
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req0      = 1'b1;
        bus.req1      = 1'b1;
        bus.out_ready = 1'b1;
        drive();
        #1;
        checks++;
        if (obs !== 13'h0) $display("FAIL reset_async obs=%h exp=%h", obs, 13'h0);
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== 13'h0) $display("FAIL reset_held obs=%h exp=%h", obs, 13'h0);
        else passes++;
    endtask

    task automatic test_single_packet();
        do_reset();
        len0 = 3;
        bus.req0 = 1'b1;
        drive();
        #1;
        checks++;
        if (obs !== 13'h0) $display("FAIL t1_idle obs=%h exp=%h", obs, 13'h0);
        else passes++;
        advance();
        for (int i = 0; i < 3; i++) begin
            #1;
            exp = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h10 + 8'(i)};
            checks++;
            if (obs !== exp) $display("FAIL t1_beat%0d obs=%h exp=%h", i, obs, exp);
            else passes++;
            advance();
        end
        // Re-granted on the last beat since req0 was still high; dropping it releases.
        bus.req0 = 1'b0;
        #1;
        exp = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h13};
        checks++;
        if (obs !== exp) $display("FAIL t1_abandon obs=%h exp=%h", obs, exp);
        else passes++;
        advance();
        #1;
        checks++;
        if (obs !== 13'h0) $display("FAIL t1_back_idle obs=%h exp=%h", obs, 13'h0);
        else passes++;
    endtask

    task automatic test_alternate();
        logic [8:0] tab [8];
        tab = '{9'h010, 9'h011, 9'h180, 9'h181, 9'h012, 9'h013, 9'h182, 9'h183};
        do_reset();
        len0 = 2;
        len1 = 2;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        drive();
        advance();
        for (int i = 0; i < 8; i++) begin
            #1;
            ent = tab[i];
            exp = {ent[8], 1'b1, 1'b1, ~ent[8], ent[8], ent[7:0]};
            checks++;
            if (obs !== exp) $display("FAIL t2_alt%0d obs=%h exp=%h", i, obs, exp);
            else passes++;
            advance();
        end
    endtask

    task automatic test_burst_limit();
        logic [8:0] tab [13];
        tab = '{9'h010, 9'h011, 9'h012, 9'h013, 9'h180,
                9'h014, 9'h015, 9'h016, 9'h017, 9'h181,
                9'h018, 9'h019, 9'h182};
        do_reset();
        len0 = 10;
        len1 = 1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        drive();
        advance();
        for (int i = 0; i < 13; i++) begin
            #1;
            ent = tab[i];
            exp = {ent[8], 1'b1, 1'b1, ~ent[8], ent[8], ent[7:0]};
            checks++;
            if (obs !== exp) $display("FAIL t3_burst%0d obs=%h exp=%h", i, obs, exp);
            else passes++;
            advance();
        end
    endtask

    task automatic test_stall();
        logic [8:0] tab [5];
        tab = '{9'h181, 9'h182, 9'h183, 9'h010, 9'h184};
        do_reset();
        len0 = 1;
        len1 = 6;
        bus.req1 = 1'b1;
        drive();
        advance();
        bus.req0 = 1'b1;
        #1;
        exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h80};
        checks++;
        if (obs !== exp) $display("FAIL t4_first obs=%h exp=%h", obs, exp);
        else passes++;
        advance();
        for (int s = 0; s < 5; s++) begin
            bus.out_ready = 1'b0;
            #1;
            exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h81};
            checks++;
            if (obs !== exp) $display("FAIL t4_stall%0d obs=%h exp=%h", s, obs, exp);
            else passes++;
            advance();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            ent = tab[i];
            exp = {ent[8], 1'b1, 1'b1, ~ent[8], ent[8], ent[7:0]};
            checks++;
            if (obs !== exp) $display("FAIL t4_resume%0d obs=%h exp=%h", i, obs, exp);
            else passes++;
            advance();
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        len1 = 3;
        bus.req1 = 1'b1;
        drive();
        advance();
        advance();
        #1;
        exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h81};
        checks++;
        if (obs !== exp) $display("FAIL t5_second_beat obs=%h exp=%h", obs, exp);
        else passes++;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 13'h0) $display("FAIL t5_async_clear obs=%h exp=%h", obs, 13'h0);
        else passes++;
        bus.req0 = 1'b1;
        len0 = 2;
        k0 = 0;
        k1 = 0;
        drive();
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== 13'h0) $display("FAIL t5_idle_after obs=%h exp=%h", obs, 13'h0);
        else passes++;
        @(posedge clk);
        #1;
        exp = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h10};
        checks++;
        if (obs !== exp) $display("FAIL t5_first_grant obs=%h exp=%h", obs, exp);
        else passes++;
    endtask

`ifdef MUX2_RR_ARBITER_STATS_EN
    task automatic test_stats();
        do_reset();
        len0 = 1;
        len1 = 1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        drive();
        for (int c = 0; c < 2000 && (k0 < 300 || k1 < 120); c++) begin
            advance();
            if (k0 >= 300) bus.req0 = 1'b0;
            if (k1 >= 120) bus.req1 = 1'b0;
        end
        advance();
        checks++;
        if (k0 != 300 || k1 != 120) $display("FAIL stats_timeout k0=%0d k1=%0d exp=300/120", k0, k1);
        else passes++;
        checks++;
        if (cnt0 !== 16'd300) $display("FAIL stats_cnt0 got=%0d exp=300", cnt0);
        else passes++;
        checks++;
        if (cnt1 !== 16'd120) $display("FAIL stats_cnt1 got=%0d exp=120", cnt1);
        else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_packet();
        test_alternate();
        test_burst_limit();
        test_stall();
        test_reset_mid_packet();
`ifdef MUX2_RR_ARBITER_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 2-to-1 mux output channel between two requesters.
- Each requester presents a data stream with a valid/ready handshake and an end-of-packet marker.
- The block drives the mux select, grants the channel for whole packets (bounded by a burst limit) and alternates fairly between requesters.
- Sits between two source blocks and a single downstream consumer.

Parameters:
- WIDTH, 8: data width of in0, in1 and out.
- MAX_BURST, 4: maximum accepted beats per grant before forced re-arbitration; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 has a valid beat on in0.
- in0  input  WIDTH  requester 0 data.
- last0  input  1  in0 beat is the last beat of its packet.
- gnt0  output  1  ready to requester 0; a beat transfers when req0 && gnt0.
- req1  input  1  requester 1 has a valid beat on in1.
- in1  input  WIDTH  requester 1 data.
- last1  input  1  in1 beat is the last beat of its packet.
- gnt1  output  1  ready to requester 1.
- out_valid  output  1  valid beat on out.
- out  output  WIDTH  muxed data.
- out_ready  input  1  downstream accepts the beat.
- sel  output  1  mux select: 0 = in0, 1 = in1.
- busy  output  1  a grant is active (state != IDLE).

Behaviour:
- Single clock domain. Reset is asynchronous and active-low on rst_n.
- State machine states: IDLE, GRANT0, GRANT1.
- Reset values: state IDLE, sel 0, busy 0, out_valid 0, out 0, gnt0 0, gnt1 0.
- Reset values of internal registers: last_served 1 (so requester 0 wins first), beat_cnt 0.
- Output decode, combinational from registered state:
  - sel = (state == GRANT1).
  - out_valid = (GRANT0 && req0) || (GRANT1 && req1).
  - out = in0 in GRANT0, in1 in GRANT1, 0 in IDLE.
  - gnt0 = GRANT0 && out_ready; gnt1 = GRANT1 && out_ready.
  - busy = (state != IDLE).
- Transfer definition: out_valid && out_ready in the current cycle.
- IDLE transitions:
  - Only req0 high -> GRANT0. Only req1 high -> GRANT1.
  - Both high -> grant the requester != last_served.
  - Arbitration latency is 1 cycle from request to first possible transfer.
- GRANT transitions: the grant is released at the clock edge after any of these:
  - (a) a transfer with the active requester's last bit set;
  - (b) a transfer that makes beat_cnt reach MAX_BURST;
  - (c) the active requester's req is low (the requester abandoned the grant).
- On release:
  - Set last_served to the released requester.
  - If the other requester's req is high, go directly to its GRANT state (no IDLE bubble).
  - Else, if the same requester's req is high, re-grant it.
  - Else go to IDLE.
- beat_cnt:
  - 8-bit, counts transfers in the current grant.
  - Cleared on every grant entry and on return to IDLE.
  - Never exceeds MAX_BURST.
- Stalls: out_ready low holds state, beat_cnt and sel; the requester must hold req, data and last until gnt.
- Burst limit with MAX_BURST = 1: strict per-beat alternation whenever both requesters are requesting.
- The non-granted requester's gnt is always 0; sel never changes mid-cycle and changes only on release.
- Reset asserted mid-packet: immediately return to reset values; the partial packet is abandoned with no recovery.

Optional Feature:
- Macro: MUX2_RR_ARBITER_STATS_EN.
- Defined:
  - Adds output ports cnt0 and cnt1 (16 bits each).
  - Each counts accepted transfers from its requester.
  - Saturates at 16'hFFFF; reset to 0 by rst_n.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then req0=1 with a 3-beat packet (last0 on beat 3), out_ready=1 -> sel=0, out = in0 beats in order, gnt0 high 3 cycles, back to IDLE, busy=0.
- req0 and req1 both held continuously, 2-beat packets each -> grants alternate 0,1,0,1; no IDLE cycle between packets; sel toggles only after each last beat.
- MAX_BURST=4, req0 sends a 10-beat packet while req1 is pending -> 4 beats from 0, then 1's packet, then the remaining 4 beats of 0, then 1, then the final 2 beats of 0.
- Granted to 1, out_ready low for 5 cycles mid-packet -> out, sel and beat_cnt hold; gnt1=0; the packet resumes unchanged when out_ready returns.
- rst_n pulsed low asynchronously during the 2nd beat of a GRANT1 packet -> outputs go to 0 immediately; after release with both requesting, the first grant goes to 0.
- With MUX2_RR_ARBITER_STATS_EN defined, run 300 single-beat transfers from 0 and 120 from 1 -> cnt0=300, cnt1=120.
